db_addr_gen: RTL and testbench

DB_ADDR_GEN -- requirements
Module: db_addr_gen

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/db_addr_gen_if.sv | 22 ++
 rtl/db_addr_gen_dim_counter.sv | 60 ++++++
 rtl/db_addr_gen.sv | 152 +++++++++++++++
 tb/tb_db_addr_gen.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller definitions: default geometry, address-generator
// state encoding and the dimensionality clamp.
package mem_ctrl_pkg;

    localparam int NUM_DIMS = 6;
    localparam int ADDR_W   = 16;
    localparam int RANGE_W  = 32;
    localparam int DIM_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Zero means one dimension; anything past the hardware limit is capped.
    function automatic logic [DIM_W-1:0] clamp_dims(input logic [DIM_W-1:0] req,
                                                    input int n_dims);
        if (req == '0) begin
            return DIM_W'(1);
        end
        if (int'(req) > n_dims) begin
            return DIM_W'(n_dims);
        end
        return req;
    endfunction

endpackage

// File: rtl/db_addr_gen_if.sv
// Address stream from the generator to the memory core (valid/ready).
interface db_addr_gen_if #(
    parameter int ADDR_W = mem_ctrl_pkg::ADDR_W
);

    logic [ADDR_W-1:0] addr_out;
    logic              addr_valid;
    logic              addr_ready;

    modport master (
        output addr_out,
        output addr_valid,
        input  addr_ready
    );

    modport slave (
        input  addr_out,
        input  addr_valid,
        output addr_ready
    );

endinterface

// File: rtl/db_addr_gen_dim_counter.sv
// One address dimension: trip counter with wrap/carry and a running
// stride offset, so no multiplier is needed.
module addr_dim_counter #(
    parameter int ADDR_W  = mem_ctrl_pkg::ADDR_W,
    parameter int RANGE_W = mem_ctrl_pkg::RANGE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic               active_i,
    input  logic               inc_i,
    input  logic [RANGE_W-1:0] range_i,
    input  logic [ADDR_W-1:0]  stride_i,
    output logic [ADDR_W-1:0]  off_next_o,
    output logic               carry_o
);

    logic [RANGE_W-1:0] cnt_q, cnt_d;
    logic [RANGE_W-1:0] last_cnt;
    logic [ADDR_W-1:0]  off_q, off_d;
    logic               at_last;

    // A zero range behaves as a single-step dimension.
    assign last_cnt = (range_i == '0) ? '0 : range_i - RANGE_W'(1);
    assign at_last  = (cnt_q == last_cnt);
    assign carry_o  = active_i && inc_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        off_d = off_q;
        if (clr_i || !active_i) begin
            cnt_d = '0;
            off_d = '0;
        end else if (inc_i) begin
            if (at_last) begin
                cnt_d = '0;
                off_d = '0;
            end else begin
                cnt_d = cnt_q + RANGE_W'(1);
                off_d = off_q + stride_i;
            end
        end
    end

    // The parent registers its address from the next offset, keeping addr_out
    // aligned with the counter state rather than one step behind.
    assign off_next_o = off_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            off_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
            off_q <= off_d;
        end
    end

endmodule

// File: rtl/db_addr_gen.sv
// Multi-dimensional address generator: emits iter_cnt addresses per pass,
// starting_addr + sum(cnt[i]*stride[i]), on a valid/ready stream.
module db_addr_gen #(
    parameter int NUM_DIMS = mem_ctrl_pkg::NUM_DIMS,
    parameter int ADDR_W   = mem_ctrl_pkg::ADDR_W,
    parameter int RANGE_W  = mem_ctrl_pkg::RANGE_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clk_en,
    input  logic                              flush,
    input  logic                              start,
    input  logic [mem_ctrl_pkg::DIM_W-1:0]    dimensionality,
    input  logic [ADDR_W-1:0]                 starting_addr,
    input  logic [NUM_DIMS-1:0][ADDR_W-1:0]   stride,
    input  logic [NUM_DIMS-1:0][RANGE_W-1:0]  range,
    input  logic [RANGE_W-1:0]                iter_cnt,
    db_addr_gen_if.master                     bus,
    output logic                              busy,
    output logic                              done
);

    import mem_ctrl_pkg::*;

    state_t                           state_q;
    logic [DIM_W-1:0]                 dims_q;
    logic [ADDR_W-1:0]                base_q;
    logic [NUM_DIMS-1:0][ADDR_W-1:0]  stride_q;
    logic [NUM_DIMS-1:0][RANGE_W-1:0] range_q;
    logic [RANGE_W-1:0]               iter_q;
    logic [RANGE_W-1:0]               emitted_q;
    logic [RANGE_W-1:0]               emitted_d;
    logic [ADDR_W-1:0]                addr_q;
    logic [ADDR_W-1:0]                addr_d;
    logic                             valid_q;
    logic                             busy_q;
    logic                             done_q;

    logic                             accept;
    logic                             advance;
    logic                             clr;
    logic [NUM_DIMS:0]                carry;
    logic [NUM_DIMS-1:0][ADDR_W-1:0]  off_next;
    logic                             unused_top_carry;

    assign accept    = (state_q == IDLE) && start;
    assign advance   = valid_q && bus.addr_ready;
    assign clr       = flush || accept;
    assign carry[0]  = advance;
    assign emitted_d = emitted_q + RANGE_W'(1);

    // The outermost carry has no consumer: pass length is governed by iter_cnt.
    assign unused_top_carry = carry[NUM_DIMS];

    for (genvar g = 0; g < NUM_DIMS; g++) begin : g_dim
        addr_dim_counter #(
            .ADDR_W  (ADDR_W),
            .RANGE_W (RANGE_W)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (reset),
            .en_i       (clk_en),
            .clr_i      (clr),
            .active_i   (g < int'(dims_q)),
            .inc_i      (carry[g]),
            .range_i    (range_q[g]),
            .stride_i   (stride_q[g]),
            .off_next_o (off_next[g]),
            .carry_o    (carry[g+1])
        );
    end

    always_comb begin
        addr_d = base_q;
        for (int i = 0; i < NUM_DIMS; i++) begin
            addr_d = addr_d + off_next[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            dims_q    <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            range_q   <= '0;
            iter_q    <= '0;
            emitted_q <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            dims_q    <= clamp_dims(dimensionality, NUM_DIMS);
                            base_q    <= starting_addr;
                            stride_q  <= stride;
                            range_q   <= range;
                            iter_q    <= iter_cnt;
                            emitted_q <= '0;
                            addr_q    <= starting_addr;
                            busy_q    <= 1'b1;
                            if (iter_cnt == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= RUN;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (advance) begin
                            addr_q    <= addr_d;
                            emitted_q <= emitted_d;
                            if (emitted_d == iter_q) begin
                                state_q <= DONE;
                                valid_q <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.addr_out   = addr_q;
    assign bus.addr_valid = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_db_addr_gen.sv
// Scoreboard bench for db_addr_gen: expected addresses are queued per pass
// and popped on every transfer.
module tb_db_addr_gen;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            clk_en = 1'b1;
    logic            flush = 1'b0;
    logic            start = 1'b0;
    logic [3:0]      dimensionality = '0;
    logic [15:0]     starting_addr = '0;
    logic [5:0][15:0] stride = '0;
    logic [5:0][31:0] range = '0;
    logic [31:0]     iter_cnt = '0;
    logic            busy;
    logic            done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    db_addr_gen_if #(.ADDR_W(16)) bus ();

    db_addr_gen #(
        .NUM_DIMS (6),
        .ADDR_W   (16),
        .RANGE_W  (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .flush          (flush),
        .start          (start),
        .dimensionality (dimensionality),
        .starting_addr  (starting_addr),
        .stride         (stride),
        .range          (range),
        .iter_cnt       (iter_cnt),
        .bus            (bus),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running after %0d comparisons", n_tests);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] model_addr(input logic [3:0] d, input logic [15:0] base,
                                               input logic [5:0][15:0] st,
                                               input logic [5:0][31:0] rg, input int k);
        int nd;
        int rem;
        int r;
        logic [15:0] a;
        nd  = (d == 4'd0) ? 1 : (d > 4'd6) ? 6 : int'(d);
        a   = base;
        rem = k;
        for (int i = 0; i < nd; i++) begin
            r   = (rg[i] == 32'd0) ? 1 : int'(rg[i]);
            a   = a + 16'((rem % r) * int'(st[i]));
            rem = rem / r;
        end
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] d, input logic [15:0] base, input logic [31:0] n);
        dimensionality = d;
        starting_addr  = base;
        iter_cnt       = n;
        stride         = '0;
        range          = '0;
    endtask

    task automatic cube(input logic [15:0] base);
        cfg(4'd3, base, 32'd27);
        stride[0] = 16'd1;
        stride[1] = 16'd3;
        stride[2] = 16'd9;
        range[0]  = 32'd3;
        range[1]  = 32'd3;
        range[2]  = 32'd3;
    endtask

    // Starts a pass, then scrambles the config inputs; the queue was filled beforehand.
    task automatic run_pass(input string name, input bit toggle);
        int cyc;
        int idx;
        bit stalled;
        bit r;
        logic [15:0] held;
        logic [15:0] exp_a;
        cyc = 0;
        idx = 0;
        stalled = 1'b0;
        held = '0;
        bus.addr_ready = !toggle;
        start = 1'b1;
        tick();
        if (!toggle) start = 1'b0;
        dimensionality = 4'd1;
        starting_addr  = starting_addr ^ 16'h5A5A;
        iter_cnt       = 32'd1;
        range[0]       = 32'd2;
        stride[0]      = 16'h0777;
        while (exp_q.size() > 0 && cyc < 400) begin
            n_tests++;
            if (bus.addr_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s status[%0d]: valid=%b done=%b busy=%b, required 1/0/1",
                         name, idx, bus.addr_valid, done, busy);
                break;
            end
            if (stalled) begin
                n_tests++;
                if (bus.addr_out !== held) begin
                    n_fail++;
                    $display("FAIL %s hold[%0d]: addr_out=%h, required %h", name, idx, bus.addr_out, held);
                end
            end
            r = toggle ? cyc[0] : 1'b1;
            bus.addr_ready = r;
            if (r) begin
                exp_a = exp_q.pop_front();
                n_tests++;
                if (bus.addr_out !== exp_a) begin
                    n_fail++;
                    $display("FAIL %s addr[%0d]: addr_out=%h, required %h", name, idx, bus.addr_out, exp_a);
                end
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = bus.addr_out;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s count: %0d addresses not transferred, required 0", name, exp_q.size());
            exp_q.delete();
        end
        n_tests++;
        if (done !== 1'b1 || bus.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: done=%b valid=%b, required 1/0", name, done, bus.addr_valid);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: done=%b busy=%b valid=%b, required 0/0/0",
                     name, done, busy, bus.addr_valid);
        end
    endtask

    task automatic test_reset();
        bus.addr_ready = 1'b0;
        #1 reset = 1'b0;
        #2;
        n_tests++;
        if (bus.addr_out !== 16'h0 || bus.addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: addr=%h valid=%b busy=%b done=%b, required 0000/0/0/0",
                     bus.addr_out, bus.addr_valid, busy, done);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if (bus.addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b busy=%b done=%b, required 0/0/0",
                     bus.addr_valid, busy, done);
        end
    endtask

    task automatic test_seq3d();
        cube(16'h0000);
        for (int k = 0; k < 27; k++) exp_q.push_back(16'(k));
        run_pass("seq3d", 1'b0);
    endtask

    task automatic test_stall();
        cube(16'h0000);
        for (int k = 0; k < 27; k++) exp_q.push_back(16'(k));
        run_pass("stall", 1'b1);
    endtask

    task automatic test_addr_wrap();
        cfg(4'd1, 16'hFFFE, 32'd3);
        stride[0] = 16'd1;
        range[0]  = 32'd8;
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        run_pass("addr_wrap", 1'b0);
    endtask

    task automatic test_early_done();
        cfg(4'd2, 16'h0000, 32'd5);
        stride[0] = 16'd1;
        stride[1] = 16'd3;
        stride[2] = 16'd50;
        range[0]  = 32'd3;
        range[1]  = 32'd3;
        range[2]  = 32'd3;
        for (int k = 0; k < 5; k++) exp_q.push_back(16'(k));
        run_pass("early_done", 1'b0);
    endtask

    task automatic test_clamp();
        cfg(4'd0, 16'h0000, 32'd6);
        stride[0] = 16'd5;
        range[0]  = 32'd4;
        stride[1] = 16'd100;
        range[1]  = 32'd2;
        for (int k = 0; k < 6; k++)
            exp_q.push_back(model_addr(dimensionality, starting_addr, stride, range, k));
        run_pass("dims_zero", 1'b0);
        cfg(4'd15, 16'h0002, 32'd10);
        range  = {32'd2, 32'd1, 32'd1, 32'd2, 32'd0, 32'd2};
        stride = {16'h1000, 16'h0007, 16'h0005, 16'h0100, 16'h0003, 16'h0010};
        for (int k = 0; k < 10; k++)
            exp_q.push_back(model_addr(dimensionality, starting_addr, stride, range, k));
        run_pass("dims_clamp", 1'b1);
    endtask

    task automatic test_zero_iter();
        cfg(4'd3, 16'h1234, 32'd0);
        bus.addr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (bus.addr_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_iter_done: valid=%b done=%b busy=%b, required 0/1/1",
                     bus.addr_valid, done, busy);
        end
        tick();
        n_tests++;
        if (bus.addr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_iter_idle: valid=%b done=%b busy=%b, required 0/0/0",
                     bus.addr_valid, done, busy);
        end
    endtask

    task automatic test_flush();
        cube(16'h0000);
        bus.addr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (bus.addr_out !== 16'd3) begin
            n_fail++;
            $display("FAIL flush_pre: addr_out=%h, required 0003", bus.addr_out);
        end
        flush = 1'b1;
        start = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        n_tests++;
        if (bus.addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_abort: valid=%b busy=%b done=%b, required 0/0/0",
                     bus.addr_valid, busy, done);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_done: done=%b busy=%b, required 0/0", done, busy);
        end
        cube(16'h0000);
        for (int k = 0; k < 27; k++) exp_q.push_back(16'(k));
        run_pass("flush_restart", 1'b0);
    endtask

    task automatic test_clk_en();
        cube(16'h0040);
        bus.addr_ready = 1'b0;
        clk_en = 1'b0;
        start = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || bus.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clk_en_start: busy=%b valid=%b, required 0/0", busy, bus.addr_valid);
        end
        clk_en = 1'b1;
        tick();
        start = 1'b0;
        bus.addr_ready = 1'b1;
        tick();
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bus.addr_out !== 16'h0041 || bus.addr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL clk_en_freeze[%0d]: addr_out=%h valid=%b, required 0041/1",
                         i, bus.addr_out, bus.addr_valid);
            end
        end
        clk_en = 1'b1;
        tick();
        n_tests++;
        if (bus.addr_out !== 16'h0042) begin
            n_fail++;
            $display("FAIL clk_en_resume: addr_out=%h, required 0042", bus.addr_out);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.addr_ready = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clk_en_flush: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_midpass();
        cube(16'h0000);
        bus.addr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        n_tests++;
        if (bus.addr_out !== 16'd10) begin
            n_fail++;
            $display("FAIL midpass_pre: addr_out=%h, required 000a", bus.addr_out);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (bus.addr_out !== 16'h0 || bus.addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midpass_reset: addr=%h valid=%b busy=%b done=%b, required 0000/0/0/0",
                     bus.addr_out, bus.addr_valid, busy, done);
        end
        tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if (bus.addr_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midpass_no_resume: valid=%b busy=%b, required 0/0", bus.addr_valid, busy);
        end
        cube(16'h0100);
        for (int k = 0; k < 27; k++) exp_q.push_back(16'h0100 + 16'(k));
        run_pass("restart_after_reset", 1'b0);
    endtask

    initial begin
        bus.addr_ready = 1'b0;
        test_reset();
        test_seq3d();
        test_stall();
        test_addr_wrap();
        test_early_done();
        test_clamp();
        test_zero_iter();
        test_flush();
        test_clk_en();
        test_reset_midpass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
